ls_unit_q: RTL

Parametrised load/store execution unit with an input request queue, alignment checking and flush support. Sits between the load/store buffer and the memory controller. Accepts up to DEPTH queued requests while one access is outstanding. Returns load results, and misalignment faults, to the ROB.

---
 rtl/ls_unit_q.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ls_unit_q.sv
// ls_unit_q: queued load/store execution unit.
// Checks alignment, issues one memory access at a time, reports to the ROB.
module ls_unit_q #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 4,
   parameter int NAME_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_store,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] in_imm,
   input  logic [31:0]       in_wdata,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [NAME_W-1:0] in_name,
   input  logic              mem_free,
   input  logic              mem_done,
   input  logic [31:0]       mem_rdata,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_len,
   output logic [31:0]       mem_wdata,
   output logic              rob_en,
   output logic              rob_err,
   output logic [31:0]       rob_data,
   output logic [TAG_W-1:0]  rob_tag,
   output logic [NAME_W-1:0] rob_name,
   output logic              done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              store;
      logic [2:0]        funct3;
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] imm;
      logic [31:0]       wdata;
      logic [TAG_W-1:0]  tag;
      logic [NAME_W-1:0] name;
   } req_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   req_t              r_q [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   state_t            r_state;
   logic              r_killed;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_len;
   logic [2:0]        r_funct3;
   logic [31:0]       r_wdata;
   logic [TAG_W-1:0]  r_tag;
   logic [NAME_W-1:0] r_name;

   req_t              w_in;
   req_t              w_head;
   logic              w_enq;
   logic              w_pop;
   logic              w_mis;
   logic [ADDR_W-1:0] w_addr;
   logic [2:0]        w_len;
   logic [31:0]       w_ext;

   assign in_ready = (r_count != CNT_W'(DEPTH));
   assign w_enq    = in_valid && in_ready && !flush;
   assign w_pop    = (r_state == IDLE) && (r_count != '0);
   assign w_head   = r_q[r_rd_ptr];
   assign w_addr   = w_head.base + w_head.imm;

   assign w_in.store  = in_store;
   assign w_in.funct3 = in_funct3;
   assign w_in.base   = in_base;
   assign w_in.imm    = in_imm;
   assign w_in.wdata  = in_wdata;
   assign w_in.tag    = in_tag;
   assign w_in.name   = in_name;

   // Head-of-queue size decode and alignment check.
   always_comb begin
      w_len = 3'b011;
      w_mis = 1'b0;
      unique case (1'b1)
         (w_head.funct3[1:0] == 2'b00): w_len = 3'b000;
         (w_head.funct3[1:0] == 2'b01): begin
            w_len = 3'b001;
            w_mis = w_addr[0];
         end
         default: begin
            w_len = 3'b011;
            w_mis = (w_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Sign/zero extension of returned load data by the latched funct3.
   always_comb begin
      w_ext = mem_rdata;
      case (r_funct3)
         3'b000:  w_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b100:  w_ext = {24'd0, mem_rdata[7:0]};
         3'b001:  w_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b101:  w_ext = {16'd0, mem_rdata[15:0]};
         default: w_ext = mem_rdata;
      endcase
   end

   // Queue storage; contents need no reset, validity lives in r_count.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q[r_wr_ptr] <= w_in;
      end
   end

   // Queue pointers and occupancy; flush empties everything at once.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Access FSM with registered memory and ROB outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_killed  <= 1'b0;
         r_rw      <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_funct3  <= '0;
         r_wdata   <= '0;
         r_tag     <= '0;
         r_name    <= '0;
         mem_req   <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_len   <= '0;
         mem_wdata <= '0;
         rob_en    <= 1'b0;
         rob_err   <= 1'b0;
         rob_data  <= '0;
         rob_tag   <= '0;
         rob_name  <= '0;
         done      <= 1'b0;
      end else begin
         mem_req  <= 1'b0;
         rob_en   <= 1'b0;
         rob_err  <= 1'b0;
         rob_data <= '0;
         rob_tag  <= '0;
         rob_name <= '0;
         done     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop && !flush) begin
                  if (w_mis) begin
                     rob_en   <= 1'b1;
                     rob_err  <= 1'b1;
                     done     <= 1'b1;
                     rob_tag  <= w_head.tag;
                     rob_name <= w_head.name;
                  end else begin
                     r_rw     <= w_head.store;
                     r_addr   <= w_addr;
                     r_len    <= w_len;
                     r_funct3 <= w_head.funct3;
                     r_wdata  <= w_head.wdata;
                     r_tag    <= w_head.tag;
                     r_name   <= w_head.name;
                     r_state  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (flush) begin
                  r_state <= IDLE;
               end else if (mem_free) begin
                  mem_req   <= 1'b1;
                  mem_rw    <= r_rw;
                  mem_addr  <= r_addr;
                  mem_len   <= r_len;
                  mem_wdata <= r_wdata;
                  r_state   <= WAIT;
               end
            end
            WAIT: begin
               if (mem_done) begin
                  done <= 1'b1;
                  if (!r_rw && !r_killed && !flush) begin
                     rob_en   <= 1'b1;
                     rob_data <= w_ext;
                     rob_tag  <= r_tag;
                     rob_name <= r_name;
                  end
                  mem_rw    <= 1'b0;
                  mem_addr  <= '0;
                  mem_len   <= '0;
                  mem_wdata <= '0;
                  r_killed  <= 1'b0;
                  r_state   <= IDLE;
               end else if (flush) begin
                  r_killed <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
